// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin arbiter sharing the register-file write port among
//               NUM_REQ writeback requesters; owns the x1..x31 clear sweep.
//               Optional sweep logic is built only when RF_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    clear_req,
    output logic [4:0]              rf_a3,
    output logic [XLEN-1:0]         rf_wd,
    output logic                    rf_wen,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int                 c_ptr_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_ptr_w:0]   c_num_req  = (c_ptr_w + 1)'(NUM_REQ);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(NUM_REQ - 1);

    logic [c_ptr_w-1:0]   r_rr_ptr;
    logic [4:0]           r_a3;
    logic [XLEN-1:0]      r_wd;
    logic                 r_wen;
    logic [7:0]           r_drop_cnt;

    logic                 w_in_arb;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_off;
    logic [c_ptr_w:0]     w_sum;
    logic [c_ptr_w:0]     w_sum_wrap;
    logic [c_ptr_w-1:0]   w_win;
    logic [c_ptr_w-1:0]   w_ptr_next;
    logic [4:0]           w_addr;
    logic [XLEN-1:0]      w_data;
    logic [NUM_REQ-1:0]   w_ready;

`ifdef RF_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    localparam logic [4:0] c_last_idx = 5'(NUM_REGS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_idx;
    logic [4:0] w_idx_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_idx   <= 5'd1;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // A clear request always (re)starts the sweep from x1.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_ARB: begin
                if (clear_req) begin
                    w_state_next = ST_CLEAR;
                    w_idx_next   = 5'd1;
                end
            end
            ST_CLEAR: begin
                if (clear_req) begin
                    w_idx_next = 5'd1;
                end else if (r_idx == c_last_idx) begin
                    w_state_next = ST_ARB;
                    w_idx_next   = 5'd1;
                end else begin
                    w_idx_next = r_idx + 5'd1;
                end
            end
            default: begin
                w_state_next = ST_ARB;
                w_idx_next   = 5'd1;
            end
        endcase
    end

    assign w_in_arb = (r_state == ST_ARB);
    assign busy     = (r_state == ST_CLEAR);
`else
    logic w_unused_clear;

    assign w_unused_clear = clear_req;
    assign w_in_arb       = 1'b1;
    assign busy           = 1'b0;
`endif

    // Rotate valids so the search starts at rr_ptr; the lowest set bit wins.
    always_comb begin
        w_rot   = {req_valid, req_valid} >> r_rr_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_ptr_w'(k);
            end
        end
        w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_sum_wrap = w_sum - c_num_req;
        w_win      = (w_sum >= c_num_req) ? w_sum_wrap[c_ptr_w-1:0] : w_sum[c_ptr_w-1:0];
    end

    always_comb begin
        w_addr  = '0;
        w_data  = '0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_ptr_w'(i)) begin
                w_addr     = req_addr[5*i +: 5];
                w_data     = req_data[XLEN*i +: XLEN];
                w_ready[i] = w_found & w_in_arb;
            end
        end
    end

    assign w_ptr_next = (w_win == c_last_ptr) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_a3       <= '0;
            r_wd       <= '0;
            r_wen      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_in_arb) begin
            if (w_found) begin
                r_a3     <= w_addr;
                r_wd     <= w_data;
                r_wen    <= (w_addr != 5'd0);
                r_rr_ptr <= w_ptr_next;
                if ((w_addr == 5'd0) && (r_drop_cnt != 8'hFF)) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else begin
                r_wen <= 1'b0;
            end
        end
`ifdef RF_CLEAR_EN
        else begin
            r_wen <= 1'b1;
            r_a3  <= r_idx;
            r_wd  <= '0;
        end
`endif
    end

    assign req_ready = w_ready;
    assign rf_a3     = r_a3;
    assign rf_wd     = r_wd;
    assign rf_wen    = r_wen;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire
